mcu0_boot_loader: RTL and testbench

- Upstream stage of the mcu0 16-bit accumulator CPU. Receives a program image as a byte stream over a valid/ready handshake and writes it into the CPU's byte-wide program memory, starting at address 0, in big-endian instruction order.
- Checks the image with an XOR checksum.
- Asserts cpu_run, which releases the CPU to fetch from PC=0, only after a complete, correct image.
- Replaces simulation-time memory preloading with a synthesizable load path.

---
 rtl/mcu0_boot_loader_if.sv | 24 ++
 rtl/mcu0_boot_loader.sv | 97 +++++++++
 tb/tb_mcu0_boot_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu0_boot_loader_if.sv
// Byte-stream and program-memory bus of the mcu0 boot loader.
// master = stream source / memory observer, slave = the loader itself.
interface mcu0_boot_loader_if #(
    parameter int AW = 5
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_run;
    logic          load_err;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err
    );
endinterface

// File: rtl/mcu0_boot_loader.sv
// Loads a SYNC/LEN/DATA/CSUM framed byte stream into mcu0 program memory
// and releases the CPU only after the XOR checksum matches.
module mcu0_boot_loader #(
    parameter int         MEM_BYTES = 32,
    parameter int         AW        = 5,
    parameter logic [7:0] SYNC      = 8'hA5
) (
    input logic                clock,
    input logic                reset_n,
    mcu0_boot_loader_if.slave  bus
);
    localparam logic [7:0] MAX_LEN = (MEM_BYTES > 255) ? 8'd255 : 8'(MEM_BYTES);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE} state_t;

    state_t        state;
    logic          ready_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic          run_q;
    logic          err_q;
    logic [7:0]    len;
    logic [7:0]    cnt;
    logic [7:0]    csum;
    logic          take;

    assign take = bus.in_valid && ready_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            len     <= '0;
            cnt     <= '0;
            csum    <= '0;
        end else begin
            we_q    <= 1'b0;
            ready_q <= (state != DONE);
            if (take) begin
                case (state)
                    IDLE: begin
                        if (bus.in_data == SYNC) begin
                            state <= LEN;
                            err_q <= 1'b0;
                            cnt   <= '0;
                            csum  <= '0;
                        end
                    end
                    LEN: begin
                        if (bus.in_data != 8'd0 && bus.in_data <= MAX_LEN) begin
                            len   <= bus.in_data;
                            state <= DATA;
                        end else begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    DATA: begin
                        // len <= MEM_BYTES keeps cnt inside the address range
                        we_q    <= 1'b1;
                        addr_q  <= cnt[AW-1:0];
                        wdata_q <= bus.in_data;
                        csum    <= csum ^ bus.in_data;
                        cnt     <= cnt + 8'd1;
                        if (cnt + 8'd1 == len) begin
                            state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (bus.in_data == csum) begin
                            state   <= DONE;
                            run_q   <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_run   = run_q;
    assign bus.load_err  = err_q;
endmodule

// File: tb/tb_mcu0_boot_loader.sv
// Directed bench for mcu0_boot_loader: framing, checksum, bounds, stalls,
// asynchronous reset and the terminal DONE state.
module tb_mcu0_boot_loader;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   wr_count = 0;

    logic [7:0] nom [4] = '{8'h00, 8'h10, 8'h10, 8'h12};

    mcu0_boot_loader_if #(.AW(5)) bus ();

    mcu0_boot_loader #(.MEM_BYTES(32), .AW(5), .SYNC(8'hA5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (bus.mem_we === 1'b1) wr_count++;
    end

    // Present a byte (called at a negedge); returns at the negedge after it is accepted.
    task automatic send(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (t >= 40) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%h in_ready=%b required=1", b, bus.in_ready);
        end
        @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_run, bus.load_err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_values rdy=%b we=%b addr=%h data=%h run=%b err=%b required all 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_run, bus.load_err);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.cpu_run !== 1'b0 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rdy=%b run=%b err=%b required rdy=1 run=0 err=0",
                     bus.in_ready, bus.cpu_run, bus.load_err);
        end
    endtask

    task automatic test_nominal();
        int w0;
        w0 = wr_count;
        send(8'hA5);
        send(8'h04);
        checks++;
        if (bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL nominal_len_no_write we=%b required 0", bus.mem_we);
        end
        for (int i = 0; i < 4; i++) begin
            send(nom[i]);
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'(i) || bus.mem_wdata !== nom[i]) begin
                errors++;
                $display("FAIL nominal_write%0d we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, i, nom[i]);
            end
        end
        send(8'h12);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.cpu_run !== 1'b1 || bus.in_ready !== 1'b0 || bus.load_err !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done run=%b rdy=%b err=%b we=%b required run=1 rdy=0 err=0 we=0",
                     bus.cpu_run, bus.in_ready, bus.load_err, bus.mem_we);
        end
        @(negedge clock);
        checks++;
        if (wr_count - w0 !== 4) begin
            errors++;
            $display("FAIL nominal_write_count got=%0d required=4", wr_count - w0);
        end
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        send(8'hA5);
        send(8'h02);
        send(8'h20);
        checks++;
        if (bus.mem_addr !== 5'd0 || bus.mem_wdata !== 8'h20) begin
            errors++;
            $display("FAIL badcs_write0 addr=%0d data=%h required addr=0 data=20", bus.mem_addr, bus.mem_wdata);
        end
        send(8'h00);
        send(8'h21);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.load_err !== 1'b1 || bus.cpu_run !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL badcs_reject err=%b run=%b rdy=%b required err=1 run=0 rdy=1",
                     bus.load_err, bus.cpu_run, bus.in_ready);
        end
        send(8'hA5);
        checks++;
        if (bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL badcs_sync_clears err=%b required 0", bus.load_err);
        end
        send(8'h01);
        send(8'h00);
        send(8'h00);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.cpu_run !== 1'b1 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL badcs_recover run=%b err=%b required run=1 err=0", bus.cpu_run, bus.load_err);
        end
    endtask

    task automatic test_len_bounds();
        int w0;
        apply_reset();
        w0 = wr_count;
        send(8'hA5);
        send(8'h00);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.load_err !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL len_zero err=%b rdy=%b required err=1 rdy=1", bus.load_err, bus.in_ready);
        end
        send(8'hA5);
        send(8'h21);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.load_err !== 1'b1) begin
            errors++;
            $display("FAIL len_33 err=%b required 1", bus.load_err);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (wr_count - w0 !== 0) begin
            errors++;
            $display("FAIL len_bad_no_write writes=%0d required=0", wr_count - w0);
        end
        send(8'hA5);
        send(8'h20);
        for (int i = 0; i < 32; i++) begin
            send(8'(i));
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'(i) || bus.mem_wdata !== 8'(i)) begin
                errors++;
                $display("FAIL len32_write%0d we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, i, 8'(i));
            end
        end
        send(8'h00);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.cpu_run !== 1'b1 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL len32_done run=%b err=%b required run=1 err=0", bus.cpu_run, bus.load_err);
        end
    endtask

    task automatic test_garbage_stalls();
        int w0;
        apply_reset();
        w0 = wr_count;
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        bus.in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (wr_count - w0 !== 0 || bus.load_err !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL garbage_dropped writes=%0d err=%b rdy=%b required writes=0 err=0 rdy=1",
                     wr_count - w0, bus.load_err, bus.in_ready);
        end
        send(8'hA5);
        send(8'h04);
        for (int i = 0; i < 4; i++) begin
            send(nom[i]);
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'(i) || bus.mem_wdata !== nom[i]) begin
                errors++;
                $display("FAIL stall_write%0d we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, i, nom[i]);
            end
            bus.in_valid = 1'b0;
            for (int g = 0; g < (i * 2 + 1) % 4; g++) begin
                bus.in_data = 8'($urandom);
                @(negedge clock);
                checks++;
                if (bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_gap_write we=%b required 0", bus.mem_we);
                end
            end
        end
        send(8'h12);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.cpu_run !== 1'b1 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_done run=%b err=%b required run=1 err=0", bus.cpu_run, bus.load_err);
        end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        send(8'hA5);
        send(8'h04);
        send(8'h00);
        send(8'h10);
        bus.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_run, bus.load_err} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset rdy=%b we=%b addr=%h data=%h run=%b err=%b required all 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_run, bus.load_err);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_ready rdy=%b required 0", bus.in_ready);
        end
        reset_n = 1'b1;
        @(negedge clock);
        test_nominal();
    endtask

    task automatic test_done_lock();
        int w0;
        w0 = wr_count;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.cpu_run !== 1'b1) begin
                errors++;
                $display("FAIL done_lock%0d rdy=%b we=%b run=%b required rdy=0 we=0 run=1",
                         c, bus.in_ready, bus.mem_we, bus.cpu_run);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (wr_count - w0 !== 0) begin
            errors++;
            $display("FAIL done_lock_writes writes=%0d required=0", wr_count - w0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_len_bounds();
        test_garbage_stalls();
        test_reset_midframe();
        test_done_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
